sdram_responder: RTL and testbench
==================================

# sdram_responder

Synthesizable SDR SDRAM device responder (MT48LC16M16-style, x16, 4 banks) that decodes the command bus driven by our SDRAM controller and serves reads and writes from an on-chip block-RAM port. It sits where the external chip would be. It serves two purposes:
- In simulation, it is the bus-functional endpoint for controller regression.
- On boards without SDRAM, it substitutes for the chip with BRAM-sized storage.

## Interface
Parameters:
- MEM_AW, 14: word-address width of the backing memory. The full address is {BA, row[12:0], col[8:0]}, truncated to the low MEM_AW bits.
- MODE_RESET, 13'h0220: mode register value after reset (CL=2, BL=1, single-write).

Ports. Clock is `clk`; `reset` is asynchronous, active-high.
- clk, in, 1: sole clock; same clock as the controller.
- reset, in, 1: asynchronous active-high reset.
- SDRAM_A, in, 13: multiplexed address.
- SDRAM_BA, in, 2: bank.
- SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE, in, 1 each: command.
- SDRAM_DQML, SDRAM_DQMH, in, 1 each: byte masks.
- SDRAM_CKE, in, 1: when low, command decode is frozen (treated as NOP).
- dq_i, in, 16: DQ sampled from the bus.
- dq_o, out, 16: read data.
- dq_oe, out, 1: drive enable for dq_o.
- mem_addr, out, MEM_AW: backing RAM word address.
- mem_we, out, 1: RAM write strobe.
- mem_be, out, 2: RAM byte enables; {~DQMH, ~DQML}.
- mem_wdata, out, 16: RAM write data.
- mem_rdata, in, 16: RAM read data; the RAM has 1-cycle registered read latency.
- proto_err, out, 1: sticky protocol-violation flag.
- err_code, out, 3: code of the first violation.

## Operation
Command decode uses {nCS, nRAS, nCAS, nWE}:
- 0011 ACTIVE, 0101 READ, 0100 WRITE, 0110 BURST TERMINATE, 0010 PRECHARGE, 0001 AUTO REFRESH, 0000 LOAD MODE.
- nCS=1 and 0111 are NOP.

Bank and mode handling:
- Each bank holds `open` and `row[12:0]`.
- ACTIVE sets open and latches SDRAM_A as the row.
- PRECHARGE with A10=1 closes all banks; with A10=0 it closes only bank BA.
- LOAD MODE latches A[12:0] into the mode register:
  - CL = A[6:4]; only 2 and 3 are valid.
  - Interleave = A[3].
  - BL = A[2:0]: 1, 2, 4, 8.
  - Single-write = A[9].
- AUTO REFRESH has no data effect.

Reads:
- READ latches bank, col = A[8:0] and auto-precharge = A10, then starts a burst of BL beats.
- Beat k column:
  - Sequential: the low log2(BL) bits of col plus k, wrapping within the BL boundary.
  - Interleaved: col XOR k.

Writes:
- WRITE writes beat 0 from dq_i on the command cycle.
- Subsequent beats are written on consecutive cycles, BL beats in total.
- When single-write is set, a write is always 1 beat.
- DQM masks bytes on every write beat.
- Reads ignore DQM; the controller selects the byte itself.

Bursts and auto-precharge:
- A new READ or WRITE, a BURST TERMINATE, or a PRECHARGE of the bursting bank ends the current burst immediately. A new READ or WRITE starts its own burst.
- Auto-precharge closes the bank after the final beat.

Burst state machine:
- States: IDLE, RBURST, WBURST.
- IDLE→RBURST on READ; IDLE→WBURST on WRITE.
- From RBURST or WBURST:
  - Return to IDLE when the beat counter reaches BL-1.
  - Return to IDLE on terminate.
  - Re-enter a burst state on a new READ or WRITE.

Reset values:
- All banks closed.
- Mode register = MODE_RESET.
- dq_o = 0, dq_oe = 0, mem_we = 0.
- proto_err = 0, err_code = 0.
- State IDLE.

## Timing
- Let T0 be the edge at which a command is sampled.
- mem_addr is combinational from the pins on the command cycle (beat 0) and from burst registers afterwards. This lets the BRAM latch the address at T0.
- Read beat k: dq_o/dq_oe are registered at edge T0+k+CL-1 and stay valid until edge T0+k+CL.
  - With CL=2, the controller samples beat 0 at T0+2.
  - CL=3 inserts one extra pipeline register.
- dq_oe drops one cycle after the last beat.
- A READ pipeline already in flight keeps delivering its already-fetched beats even if a WRITE arrives. A WRITE landing on a dq_oe cycle is a bus conflict and sets err_code 5.
- Write beat k: mem_we is combinational on cycle T0+k, with mem_wdata = dq_i.
- A READ and a new command on consecutive cycles are legal; there is no dead cycle.
- Reset mid-burst aborts the burst and drops dq_oe asynchronously.

## Configuration
SDRAM_RESP_CHECK_EN enables a protocol checker. When defined, proto_err latches and err_code records the first violation:
- 1: READ or WRITE to a closed bank.
- 2: ACTIVE to an already open bank.
- 3: AUTO REFRESH with any bank open.
- 4: LOAD MODE with any bank open, or a CL value outside {2, 3}.
- 5: WRITE during a read drive cycle.
- 6: READ or WRITE issued before tRCD=3 cycles after ACTIVE.

When undefined, proto_err and err_code are tied to 0 and the checker logic is absent. Functional behaviour is identical in both builds.

## Structure
- Package sdram_resp_pkg holds:
  - Command encoding constants.
  - Mode-register field positions.
  - The burst-state enum.
  - err_code values.
- Sub-module sdram_resp_bank is instantiated ×4. It holds open/row/tRCD counter and has ACTIVE/PRECHARGE inputs.
- Top level holds decode, the burst counter, the read pipeline, the memory port and the checker.

## Test plan
- LOAD MODE 13'h0220; ACTIVE BA=1 row=5; after 3 NOPs, WRITE col=3 data=16'hA55A; READ col=3 → dq_o=16'hA55A sampled at T0+2, dq_oe high for exactly 1 cycle.
- BL=4 sequential, col=6: read → beats at cols 6, 7, 4, 5 on consecutive cycles. With interleaved set, the same read returns cols 6, 7, 4, 5 (XOR order).
- WRITE with DQMH=1 and data 16'h1234 over a location holding 16'hFFFF → a later read returns 16'hFF34.
- CL=3, BL=8 read terminated by BURST TERMINATE at beat 2 → exactly 3 beats are driven, then dq_oe=0.
- Build with SDRAM_RESP_CHECK_EN; READ without ACTIVE → proto_err=1, err_code=1. A subsequent ACTIVE to the same bank twice does not change err_code.
- Assert reset during a BL=8 read → dq_oe=0 immediately. A READ after reset → err_code 1, because all banks are closed.

Source files
------------

// File: rtl/sdram_resp_pkg.sv
// sdram_resp_pkg: command encodings, mode-register fields, burst states and error codes
package sdram_resp_pkg;
  localparam logic [3:0] CMD_LMR = 4'b0000, CMD_REF = 4'b0001, CMD_PRE = 4'b0010, CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR = 4'b0100, CMD_RD = 4'b0101, CMD_BT = 4'b0110, CMD_NOP = 4'b0111;
  localparam int MR_BL = 0, MR_IL = 3, MR_CL = 4, MR_WB = 9;
  localparam logic [2:0] ERR_CLOSED = 3'd1, ERR_REOPEN = 3'd2, ERR_REF = 3'd3;
  localparam logic [2:0] ERR_LMR = 3'd4, ERR_BUS = 3'd5, ERR_RCD = 3'd6;
  typedef enum logic [1:0] {IDLE, RBURST, WBURST} burst_e;
  function automatic logic [2:0] bl_last(input logic [2:0] code);
    return code == 3'd0 ? 3'd0 : code == 3'd1 ? 3'd1 : code == 3'd2 ? 3'd3 : 3'd7;
  endfunction
endpackage

// File: rtl/sdram_responder_if.sv
// sdram_responder_if: SDRAM pin bundle between controller (master) and responder (slave)
interface sdram_responder_if;
  logic [12:0] SDRAM_A;
  logic [1:0] SDRAM_BA;
  logic SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE;
  logic SDRAM_DQML, SDRAM_DQMH, SDRAM_CKE;
  logic [15:0] dq_i, dq_o;
  logic dq_oe;
  modport master(output SDRAM_A, SDRAM_BA, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
                 SDRAM_DQML, SDRAM_DQMH, SDRAM_CKE, dq_i, input dq_o, dq_oe);
  modport slave(input SDRAM_A, SDRAM_BA, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
                SDRAM_DQML, SDRAM_DQMH, SDRAM_CKE, dq_i, output dq_o, dq_oe);
endinterface

// File: rtl/sdram_resp_bank.sv
// sdram_resp_bank: per-bank open flag and row; tRCD counter only with SDRAM_RESP_CHECK_EN
module sdram_resp_bank (
  input  logic        clk,
  input  logic        reset,
  input  logic        act,
  input  logic        pre,
  input  logic [12:0] row_in,
  output logic        is_open,
  output logic [12:0] row
`ifdef SDRAM_RESP_CHECK_EN
  , output logic      rcd_ok
`endif
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      is_open <= 1'b0;
      row <= '0;
    end else if (act) begin
      is_open <= 1'b1;
      row <= row_in;
    end else if (pre) is_open <= 1'b0;
`ifdef SDRAM_RESP_CHECK_EN
  logic [1:0] rcd;
  always_ff @(posedge clk or posedge reset)
    if (reset) rcd <= '0;
    else rcd <= act ? 2'd2 : rcd == 2'd0 ? 2'd0 : rcd - 2'd1;
  assign rcd_ok = rcd == 2'd0;
`endif
endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: SDR SDRAM device model over a BRAM port; SDRAM_RESP_CHECK_EN adds a protocol checker
module sdram_responder import sdram_resp_pkg::*; #(
  parameter int          MEM_AW     = 14,
  parameter logic [12:0] MODE_RESET = 13'h0220
) (
  input  logic              clk,
  input  logic              reset,
  sdram_responder_if.slave  bus,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              proto_err,
  output logic [2:0]        err_code
);
  function automatic logic [MEM_AW-1:0] word_addr(input logic [1:0] b, input logic [12:0] r, input logic [8:0] c);
    return MEM_AW'({b, r, c});
  endfunction
  logic [3:0] cmd;
  logic [12:0] a;
  logic [1:0] ba;
  logic is_act, is_rd, is_wr, is_bt, is_pre, is_lmr, rw;
  assign a = bus.SDRAM_A;
  assign ba = bus.SDRAM_BA;
  assign cmd = (!bus.SDRAM_CKE || bus.SDRAM_nCS) ? CMD_NOP : {1'b0, bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE};
  assign is_act = cmd == CMD_ACT;
  assign is_rd = cmd == CMD_RD;
  assign is_wr = cmd == CMD_WR;
  assign is_bt = cmd == CMD_BT;
  assign is_pre = cmd == CMD_PRE;
  assign is_lmr = cmd == CMD_LMR;
  assign rw = is_rd || is_wr;
  logic [2:0] bl_code;
  logic il, wb, cl3;
  always_ff @(posedge clk or posedge reset)
    if (reset) {cl3, il, wb, bl_code} <= {MODE_RESET[MR_CL +: 3] == 3'd3, MODE_RESET[MR_IL], MODE_RESET[MR_WB], MODE_RESET[MR_BL +: 3]};
    else if (is_lmr) {cl3, il, wb, bl_code} <= {a[MR_CL +: 3] == 3'd3, a[MR_IL], a[MR_WB], a[MR_BL +: 3]};
  burst_e state, state_n;
  logic [2:0] cnt, cnt_n, b_last, len_last;
  logic [1:0] b_bank, ap_bank;
  logic [12:0] b_row;
  logic [8:0] b_col, col_k;
  logic b_ap, cont, last_beat, ap_close, rd_beat;
  logic [3:0] is_open;
  logic [12:0] row [4];
`ifdef SDRAM_RESP_CHECK_EN
  logic [3:0] rcd_ok;
`endif
  for (genvar i = 0; i < 4; i++) begin : g_bank
    sdram_resp_bank u_bank (
      .clk(clk), .reset(reset),
      .act(is_act && ba == 2'(i)),
      .pre((is_pre && (a[10] || ba == 2'(i))) || (ap_close && ap_bank == 2'(i))),
      .row_in(a), .is_open(is_open[i]), .row(row[i])
`ifdef SDRAM_RESP_CHECK_EN
      , .rcd_ok(rcd_ok[i])
`endif
    );
  end
  // a burst continues only on cycles with no interrupting command
  assign len_last = (is_wr && wb) ? 3'd0 : bl_last(bl_code);
  assign cont = state != IDLE && !rw && !is_bt && !(is_pre && (a[10] || ba == b_bank));
  assign last_beat = cnt == b_last;
  assign ap_bank = rw ? ba : b_bank;
  assign ap_close = (cont && last_beat && b_ap) || (rw && len_last == 3'd0 && a[10]);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (rw) begin
      state_n = len_last == 3'd0 ? IDLE : is_rd ? RBURST : WBURST;
      cnt_n = 3'd1;
    end else if (state != IDLE) begin
      state_n = (!cont || last_beat) ? IDLE : state;
      cnt_n = cnt + 3'd1;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      b_last <= '0;
      b_bank <= '0;
      b_row <= '0;
      b_col <= '0;
      b_ap <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (rw) begin
        b_last <= len_last;
        b_bank <= ba;
        b_row <= row[ba];
        b_col <= a[8:0];
        b_ap <= a[10];
      end
    end
  assign col_k = il ? b_col ^ {6'd0, cnt} : {b_col[8:3], (b_col[2:0] & ~b_last) | ((b_col[2:0] + cnt) & b_last)};
  assign mem_addr = rw ? word_addr(ba, row[ba], a[8:0]) : word_addr(b_bank, b_row, col_k);
  assign mem_we = is_wr || (state == WBURST && cont);
  assign mem_be = {~bus.SDRAM_DQMH, ~bus.SDRAM_DQML};
  assign mem_wdata = bus.dq_i;
  assign rd_beat = is_rd || (state == RBURST && cont);
  logic rv1, rv2;
  logic [15:0] rd2;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rv1 <= 1'b0;
      rv2 <= 1'b0;
      rd2 <= '0;
      bus.dq_o <= '0;
      bus.dq_oe <= 1'b0;
    end else begin
      rv1 <= rd_beat;
      rv2 <= rv1;
      rd2 <= mem_rdata;
      bus.dq_oe <= cl3 ? rv2 : rv1;
      bus.dq_o <= cl3 ? rd2 : mem_rdata;
    end
`ifdef SDRAM_RESP_CHECK_EN
  logic [2:0] err_n;
  logic is_ref;
  assign is_ref = cmd == CMD_REF;
  assign err_n = (rw && !is_open[ba]) ? ERR_CLOSED :
                 (is_act && is_open[ba]) ? ERR_REOPEN :
                 (is_ref && |is_open) ? ERR_REF :
                 (is_lmr && (|is_open || (a[6:4] != 3'd2 && a[6:4] != 3'd3))) ? ERR_LMR :
                 (is_wr && bus.dq_oe) ? ERR_BUS :
                 (rw && !rcd_ok[ba]) ? ERR_RCD : 3'd0;
  always_ff @(posedge clk or posedge reset)
    if (reset) err_code <= '0;
    else if (err_code == 3'd0) err_code <= err_n;
  assign proto_err = err_code != 3'd0;
`else
  assign proto_err = 1'b0;
  assign err_code = 3'd0;
`endif
endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed checks of reads, writes, bursts, masks, reset and protocol errors
module tb_sdram_responder;
  import sdram_resp_pkg::*;
`ifdef SDRAM_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [13:0] mem_addr, addr_s;
  logic mem_we, we_s, proto_err;
  logic [1:0] mem_be, be_s;
  logic [15:0] mem_wdata, mem_rdata;
  logic [2:0] err_code;
  logic [15:0] ram [1 << 14];
  logic [15:0] rd_q [$];
  int checks = 0, failures = 0;
  sdram_responder_if bus();
  sdram_responder dut (
    .clk(clk), .reset(reset), .bus(bus), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .proto_err(proto_err), .err_code(err_code)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we && mem_be[0]) ram[mem_addr][7:0] <= mem_wdata[7:0];
    if (mem_we && mem_be[1]) ram[mem_addr][15:8] <= mem_wdata[15:8];
  end
  always @(negedge clk) if (bus.dq_oe) rd_q.push_back(bus.dq_o);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_q(input string tag, input logic [15:0] exp [$]);
    check({tag, "_n"}, rd_q.size(), exp.size());
    foreach (exp[i]) check($sformatf("%s_%0d", tag, i), i < rd_q.size() ? {16'h0, rd_q[i]} : 32'hDEAD_BEEF, exp[i]);
    rd_q.delete();
  endtask
  function automatic logic [2:0] ecode(input logic [2:0] x);
    return CHK ? x : 3'd0;
  endfunction
  task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [15:0] d = 16'h0, input logic [1:0] m = 2'b00);
    {bus.SDRAM_nCS, bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = c;
    bus.SDRAM_BA = b;
    bus.SDRAM_A = a;
    bus.dq_i = d;
    {bus.SDRAM_DQMH, bus.SDRAM_DQML} = m;
    #2;
    we_s = mem_we;
    addr_s = mem_addr;
    be_s = mem_be;
    @(posedge clk);
    #1;
    {bus.SDRAM_nCS, bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = CMD_NOP;
  endtask
  task automatic nop(input int n);
    repeat (n) issue(CMD_NOP, 2'd0, 13'd0);
  endtask
  task automatic set_mode(input logic [12:0] m);
    issue(CMD_PRE, 2'd0, 13'h400);
    issue(CMD_LMR, 2'd0, m);
    issue(CMD_ACT, 2'd1, 13'd5);
    nop(2);
  endtask
  task automatic do_reset;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    {bus.SDRAM_nCS, bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = CMD_NOP;
    {bus.SDRAM_BA, bus.SDRAM_A, bus.dq_i, bus.SDRAM_DQMH, bus.SDRAM_DQML} = '0;
    bus.SDRAM_CKE = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_oe", bus.dq_oe, 0);
    check("rst_dqo", bus.dq_o, 0);
    check("rst_we", mem_we, 0);
    check("rst_perr", proto_err, 0);
    check("rst_code", err_code, 0);
    reset = 1'b0;
    issue(CMD_LMR, 2'd0, 13'h0220);
    issue(CMD_ACT, 2'd1, 13'd5);
    nop(3);
    issue(CMD_WR, 2'd1, 13'd3, 16'hA55A);
    check("wr_we", we_s, 1);
    check("wr_addr", addr_s, 14'hA03);
    check("wr_be", be_s, 2'b11);
    bus.SDRAM_CKE = 1'b0;
    issue(CMD_WR, 2'd1, 13'd3, 16'hDEAD);
    check("cke_we", we_s, 0);
    bus.SDRAM_CKE = 1'b1;
    rd_q.delete();
    issue(CMD_RD, 2'd1, 13'd3);
    check("rd_oe_t1", bus.dq_oe, 0);
    nop(1);
    check("rd_oe_t2", bus.dq_oe, 1);
    check("rd_data", bus.dq_o, 16'hA55A);
    nop(1);
    check("rd_oe_off", bus.dq_oe, 0);
    check_q("cl2_bl1", '{16'hA55A});
    issue(CMD_WR, 2'd1, 13'd0, 16'h0A00);
    issue(CMD_WR, 2'd1, 13'd1, 16'h0A01);
    issue(CMD_WR, 2'd1, 13'd2, 16'h0A02);
    set_mode(13'h0022);
    issue(CMD_WR, 2'd1, 13'd4, 16'h4444);
    check("wb_a0", addr_s, 14'hA04);
    issue(CMD_NOP, 2'd0, 13'd0, 16'h5555);
    check("wb_we1", we_s, 1);
    check("wb_a1", addr_s, 14'hA05);
    issue(CMD_NOP, 2'd0, 13'd0, 16'h6666);
    check("wb_a2", addr_s, 14'hA06);
    issue(CMD_NOP, 2'd0, 13'd0, 16'h7777);
    check("wb_a3", addr_s, 14'hA07);
    issue(CMD_NOP, 2'd0, 13'd0, 16'h9999);
    check("wb_end", we_s, 0);
    rd_q.delete();
    issue(CMD_RD, 2'd1, 13'd6);
    nop(6);
    check_q("bl4_seq6", '{16'h6666, 16'h7777, 16'h4444, 16'h5555});
    issue(CMD_RD, 2'd1, 13'd6);
    issue(CMD_RD, 2'd1, 13'd4);
    nop(6);
    check_q("rd_b2b", '{16'h6666, 16'h4444, 16'h5555, 16'h6666, 16'h7777});
    set_mode(13'h002A);
    rd_q.delete();
    issue(CMD_RD, 2'd1, 13'd6);
    nop(6);
    check_q("bl4_il6", '{16'h6666, 16'h7777, 16'h4444, 16'h5555});
    issue(CMD_RD, 2'd1, 13'd5);
    nop(6);
    check_q("bl4_il5", '{16'h5555, 16'h4444, 16'h7777, 16'h6666});
    set_mode(13'h0220);
    issue(CMD_WR, 2'd1, 13'd8, 16'hFFFF);
    issue(CMD_WR, 2'd1, 13'd8, 16'h1234, 2'b10);
    check("dqmh_be", be_s, 2'b01);
    rd_q.delete();
    issue(CMD_RD, 2'd1, 13'd8);
    nop(3);
    check_q("dqmh", '{16'hFF34});
    set_mode(13'h0033);
    rd_q.delete();
    issue(CMD_RD, 2'd1, 13'd0);
    issue(CMD_NOP, 2'd0, 13'd0);
    check("cl3_t1", bus.dq_oe, 0);
    issue(CMD_NOP, 2'd0, 13'd0);
    check("cl3_t2", bus.dq_oe, 1);
    issue(CMD_BT, 2'd0, 13'd0);
    nop(6);
    check_q("cl3_bt", '{16'h0A00, 16'h0A01, 16'h0A02});
    check("bt_oe", bus.dq_oe, 0);
    check("clean_err", err_code, 0);
    issue(CMD_RD, 2'd2, 13'd0);
    nop(1);
    check("closed_code", err_code, ecode(ERR_CLOSED));
    check("closed_perr", proto_err, CHK);
    issue(CMD_ACT, 2'd2, 13'd1);
    issue(CMD_ACT, 2'd2, 13'd1);
    nop(1);
    check("sticky_code", err_code, ecode(ERR_CLOSED));
    issue(CMD_RD, 2'd1, 13'd0);
    nop(2);
    check("pre_rst_oe", bus.dq_oe, 1);
    #2 reset = 1'b1;
    #1 check("rst_async_oe", bus.dq_oe, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    nop(4);
    check("post_rst_oe", bus.dq_oe, 0);
    check("post_rst_err", err_code, 0);
    issue(CMD_RD, 2'd1, 13'd0);
    nop(1);
    check("rst_closed", err_code, ecode(ERR_CLOSED));
    do_reset();
    issue(CMD_ACT, 2'd3, 13'd0);
    issue(CMD_ACT, 2'd3, 13'd0);
    nop(1);
    check("err_reopen", err_code, ecode(ERR_REOPEN));
    do_reset();
    issue(CMD_ACT, 2'd0, 13'd0);
    issue(CMD_RD, 2'd0, 13'd0);
    nop(1);
    check("err_rcd", err_code, ecode(ERR_RCD));
    do_reset();
    issue(CMD_ACT, 2'd0, 13'd0);
    nop(2);
    rd_q.delete();
    issue(CMD_RD, 2'd0, 13'd0);
    issue(CMD_NOP, 2'd0, 13'd0);
    issue(CMD_WR, 2'd0, 13'd1, 16'hBEEF);
    nop(3);
    check("err_bus", err_code, ecode(ERR_BUS));
    check("bus_beats", rd_q.size(), 1);
    do_reset();
    issue(CMD_ACT, 2'd0, 13'd0);
    issue(CMD_REF, 2'd0, 13'd0);
    nop(1);
    check("err_ref", err_code, ecode(ERR_REF));
    do_reset();
    issue(CMD_LMR, 2'd0, 13'h0210);
    nop(1);
    check("err_lmr", err_code, ecode(ERR_LMR));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
